// File: rtl/cla_mul_seq.sv
// Sequential 32x32 -> 64 shift-and-add multiplier that borrows the ALU's shared
// carry-lookahead adder through a req/gnt handshake, one adder pass per cycle.
`timescale 1ns/1ps
module cla_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             adder_req,
  input  logic             adder_gnt,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  input  logic [WIDTH-1:0] adder_s,
  input  logic             adder_cout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEG_A  = 3'd1,
    NEG_B  = 3'd2,
    MUL    = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t           state_r;
  state_t           state_n;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] acc_hi_r;
  logic [WIDTH-1:0] acc_lo_r;
  logic [5:0]       cnt_r;
  logic             neg_res_r;
  logic             ncarry_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] product_hi_r;
  logic [WIDTH-1:0] product_lo_r;

  logic             accept_s;
  logic             fire_s;
  logic             last_step_s;
  logic             finish_s;
  logic [WIDTH-1:0] mul_hi_s;
  logic [WIDTH-1:0] mul_lo_s;
  logic [WIDTH-1:0] final_hi_s;
  logic [WIDTH-1:0] final_lo_s;

  assign accept_s    = (state_r == IDLE) && start;
  assign fire_s      = (state_r != IDLE) && adder_gnt;
  assign last_step_s = (cnt_r == LAST_STEP);
  assign finish_s    = fire_s && (((state_r == MUL) && last_step_s && !neg_res_r) ||
                                  (state_r == NEG_HI));

  // One shift-add step: the adder carry becomes the new top bit, the sum LSB drops into acc_lo.
  assign mul_hi_s = {adder_cout, adder_s[WIDTH-1:1]};
  assign mul_lo_s = {adder_s[0], acc_lo_r[WIDTH-1:1]};

  assign busy       = busy_r;
  assign adder_req  = busy_r;
  assign done       = done_r;
  assign product_hi = product_hi_r;
  assign product_lo = product_lo_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != IDLE);
    end
  end

  // Next-state logic; every non-idle state advances only on a granted cycle.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (signed_op && a[WIDTH-1]) begin
            state_n = NEG_A;
          end else if (signed_op && b[WIDTH-1]) begin
            state_n = NEG_B;
          end else begin
            state_n = MUL;
          end
        end else begin
          state_n = IDLE;
        end
      end
      NEG_A: begin
        // acc_lo still holds the raw multiplier here, so its MSB tells whether b was negative.
        if (adder_gnt) begin
          state_n = acc_lo_r[WIDTH-1] ? NEG_B : MUL;
        end else begin
          state_n = NEG_A;
        end
      end
      NEG_B: begin
        if (adder_gnt) begin
          state_n = MUL;
        end else begin
          state_n = NEG_B;
        end
      end
      MUL: begin
        if (adder_gnt && last_step_s) begin
          state_n = neg_res_r ? NEG_LO : IDLE;
        end else begin
          state_n = MUL;
        end
      end
      NEG_LO: begin
        if (adder_gnt) begin
          state_n = NEG_HI;
        end else begin
          state_n = NEG_LO;
        end
      end
      NEG_HI: begin
        if (adder_gnt) begin
          state_n = IDLE;
        end else begin
          state_n = NEG_HI;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Adder operands, driven purely from registered state so stalls keep them stable.
  always_comb begin
    adder_a   = {WIDTH{1'b0}};
    adder_b   = {WIDTH{1'b0}};
    adder_cin = 1'b0;
    case (state_r)
      NEG_A: begin
        adder_a   = ~mcand_r;
        adder_cin = 1'b1;
      end
      NEG_B: begin
        adder_a   = ~acc_lo_r;
        adder_cin = 1'b1;
      end
      MUL: begin
        adder_a = acc_hi_r;
        if (acc_lo_r[0]) begin
          adder_b = mcand_r;
        end else begin
          adder_b = {WIDTH{1'b0}};
        end
      end
      NEG_LO: begin
        adder_a   = ~acc_lo_r;
        adder_cin = 1'b1;
      end
      NEG_HI: begin
        adder_a   = ~acc_hi_r;
        adder_cin = ncarry_r;
      end
      default: begin
        adder_a   = {WIDTH{1'b0}};
        adder_b   = {WIDTH{1'b0}};
        adder_cin = 1'b0;
      end
    endcase
  end

  // Value written to the product registers on the finishing edge.
  always_comb begin
    final_hi_s = mul_hi_s;
    final_lo_s = mul_lo_s;
    if (state_r == NEG_HI) begin
      final_hi_s = adder_s;
      final_lo_s = acc_lo_r;
    end else begin
      final_hi_s = mul_hi_s;
      final_lo_s = mul_lo_s;
    end
  end

  // Datapath registers and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r      <= {WIDTH{1'b0}};
      acc_hi_r     <= {WIDTH{1'b0}};
      acc_lo_r     <= {WIDTH{1'b0}};
      cnt_r        <= 6'd0;
      neg_res_r    <= 1'b0;
      ncarry_r     <= 1'b0;
      done_r       <= 1'b0;
      product_hi_r <= {WIDTH{1'b0}};
      product_lo_r <= {WIDTH{1'b0}};
    end else begin
      done_r <= finish_s;
      if (accept_s) begin
        mcand_r   <= a;
        acc_lo_r  <= b;
        acc_hi_r  <= {WIDTH{1'b0}};
        cnt_r     <= 6'd0;
        neg_res_r <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        ncarry_r  <= 1'b0;
      end else if (fire_s) begin
        case (state_r)
          NEG_A:  mcand_r <= adder_s;
          NEG_B:  acc_lo_r <= adder_s;
          MUL: begin
            acc_hi_r <= mul_hi_s;
            acc_lo_r <= mul_lo_s;
            cnt_r    <= cnt_r + 6'd1;
          end
          NEG_LO: begin
            acc_lo_r <= adder_s;
            ncarry_r <= adder_cout;
          end
          NEG_HI: acc_hi_r <= adder_s;
          default: begin
            mcand_r <= mcand_r;
          end
        endcase
      end else begin
        mcand_r <= mcand_r;
      end
      if (finish_s) begin
        product_hi_r <= final_hi_s;
        product_lo_r <= final_lo_s;
      end else begin
        product_hi_r <= product_hi_r;
        product_lo_r <= product_lo_r;
      end
    end
  end

endmodule
